// File: rtl/rv_alu_pkg.sv
// Shared constants for the RV32I ALU: funct3 operation codes and default widths.
package rv_alu_pkg;

  localparam int ALU_DATA_W  = 32;
  localparam int ALU_SHAMT_W = $clog2(ALU_DATA_W);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

endpackage

// File: rtl/rv_alu_if.sv
// Operand/result bundle between the datapath and rv_alu.
// in_alt exists only when RV_ALU_ALT_OPS_EN is defined.
interface rv_alu_if #(
  parameter int DATA_W = rv_alu_pkg::ALU_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [2:0]        in_select;
`ifdef RV_ALU_ALT_OPS_EN
  logic              in_alt;
`endif
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data1, in_data2, in_select,
`ifdef RV_ALU_ALT_OPS_EN
    output in_alt,
`endif
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data1, in_data2, in_select,
`ifdef RV_ALU_ALT_OPS_EN
    input  in_alt,
`endif
    output out_valid, out_data
  );

endinterface

// File: rtl/rv_alu_shifter.sv
// Combinational log2(DATA_W)-stage barrel shifter; left shifts reuse the
// right-shift network by bit-reversing the operand on the way in and out.
module rv_alu_shifter #(
  parameter int DATA_W  = rv_alu_pkg::ALU_DATA_W,
  parameter int SHAMT_W = rv_alu_pkg::ALU_SHAMT_W
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_dir_left,
  input  logic               i_arith,
  output logic [DATA_W-1:0]  o_data
);

  logic [DATA_W-1:0] w_stage [SHAMT_W+1];
  logic [DATA_W-1:0] w_in_rev;
  logic [DATA_W-1:0] w_out_rev;
  logic              w_fill;

  genvar gi;

  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign w_in_rev[gi]  = i_data[DATA_W-1-gi];
      assign w_out_rev[gi] = w_stage[SHAMT_W][DATA_W-1-gi];
    end
  endgenerate

  // Sign fill only makes sense for right shifts.
  assign w_fill     = i_arith & ~i_dir_left & i_data[DATA_W-1];
  assign w_stage[0] = i_dir_left ? w_in_rev : i_data;

  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      assign w_stage[gi+1] = i_shamt[gi]
                           ? {{STEP{w_fill}}, w_stage[gi][DATA_W-1:STEP]}
                           : w_stage[gi];
    end
  endgenerate

  assign o_data = i_dir_left ? w_out_rev : w_stage[SHAMT_W];

endmodule

// File: rtl/rv_alu.sv
// RV32I integer ALU: funct3-selected op mux feeding a registered result.
// Optional SUB/SRA via funct7[5] when RV_ALU_ALT_OPS_EN is defined.
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  rv_alu_if.slave     bus
);

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_result;
  logic              w_alt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  assign w_a = bus.in_data1;
  assign w_b = bus.in_data2;

`ifdef RV_ALU_ALT_OPS_EN
  assign w_alt = bus.in_alt;
`else
  assign w_alt = 1'b0;
`endif

  rv_alu_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .i_data     (w_a),
    .i_shamt    (w_b[SHAMT_W-1:0]),
    .i_dir_left (bus.in_select == ALU_SLL),
    .i_arith    (w_alt),
    .o_data     (w_shift)
  );

  always_comb begin
    w_result = '0;
    case (bus.in_select)
      ALU_ADD:  w_result = w_alt ? (w_a - w_b) : (w_a + w_b);
      ALU_SLL:  w_result = w_shift;
      ALU_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_SLTU: w_result = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
      ALU_XOR:  w_result = w_a ^ w_b;
      ALU_SRL:  w_result = w_shift;
      ALU_OR:   w_result = w_a | w_b;
      ALU_AND:  w_result = w_a & w_b;
      default:  w_result = '0;
    endcase
  end

  // out_data holds the last result across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_data <= w_result;
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu; ALT cases run when
// RV_ALU_ALT_OPS_EN is defined.
module tb_rv_alu;
  import rv_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rv_alu_if bus ();

  rv_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic alt, input logic vld);
    @(negedge clk);
    bus.in_valid  = vld;
    bus.in_data1  = a;
    bus.in_data2  = b;
    bus.in_select = sel;
`ifdef RV_ALU_ALT_OPS_EN
    bus.in_alt    = alt;
`else
    if (alt) $display("note: alt requested without RV_ALU_ALT_OPS_EN");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(32'd1, 32'd2, ALU_ADD, 1'b0, 1'b1);
    checks++;
    if (bus.out_data !== 32'd3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_add: data=%h valid=%b expected 00000003/1", bus.out_data, bus.out_valid);
    end else $display("ok   pre_reset_add data=%h", bus.out_data);
    // Assert reset in the middle of the low clock phase, no edge in between.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_data !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h valid=%b expected 00000000/0", bus.out_data, bus.out_valid);
    end else $display("ok   async_reset");
    bus.in_valid  = 1'b1;
    bus.in_data1  = 32'd4;
    bus.in_data2  = 32'd4;
    bus.in_select = ALU_ADD;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_data !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_in_reset: data=%h valid=%b expected 00000000/0", bus.out_data, bus.out_valid);
    end else $display("ok   held_in_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_data !== 32'd8 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: data=%h valid=%b expected 00000008/1", bus.out_data, bus.out_valid);
    end else $display("ok   first_capture data=%h", bus.out_data);
  endtask

  task automatic test_vectors(input string tag, input logic [31:0] va[], input logic [31:0] vb[],
                              input logic [2:0] vs[], input logic [31:0] ve[]);
    for (int i = 0; i < va.size(); i++) begin
      drive(va[i], vb[i], vs[i], 1'b0, 1'b1);
      checks++;
      if (bus.out_data !== ve[i] || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d]: A=%h B=%h sel=%b data=%h valid=%b expected %h/1",
                 tag, i, va[i], vb[i], vs[i], bus.out_data, bus.out_valid, ve[i]);
      end else $display("ok   %s[%0d] A=%h B=%h sel=%b data=%h", tag, i, va[i], vb[i], vs[i], bus.out_data);
    end
  endtask

  task automatic test_logic();
    logic [31:0] va[] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3};
    logic [31:0] vb[] = '{32'd0, 32'd2, 32'd4, 32'd4, 32'd2};
    logic [2:0]  vs[] = '{ALU_ADD, ALU_ADD, ALU_XOR, ALU_OR, ALU_AND};
    logic [31:0] ve[] = '{32'd0, 32'd3, 32'd6, 32'd7, 32'd2};
    test_vectors("logic", va, vb, vs, ve);
  endtask

  task automatic test_shifts();
    logic [31:0] va[] = '{32'd1, 32'd17, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0001, 32'h0000_0001};
    logic [31:0] vb[] = '{32'd5, 32'd1,  32'h21,        32'h20,        32'd31,        32'h3F};
    logic [2:0]  vs[] = '{ALU_SLL, ALU_SRL, ALU_SRL, ALU_SLL, ALU_SRL, ALU_SLL};
    logic [31:0] ve[] = '{32'd32, 32'd8, 32'h4000_0000, 32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};
    test_vectors("shift", va, vb, vs, ve);
  endtask

  task automatic test_compares();
    logic [31:0] va[] = '{32'hFFFF_FFF6, 32'd10, 32'hFFFF_FFF6, 32'd10, 32'd5, 32'd7, 32'd7};
    logic [31:0] vb[] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd10, 32'd7, 32'd7};
    logic [2:0]  vs[] = '{ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU, ALU_SLTU, ALU_SLT, ALU_SLTU};
    logic [31:0] ve[] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
    test_vectors("cmp", va, vb, vs, ve);
  endtask

  task automatic test_wrap_hold();
    drive(32'hFFFF_FFFF, 32'd1, ALU_ADD, 1'b0, 1'b1);
    checks++;
    if (bus.out_data !== 32'd0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: data=%h valid=%b expected 00000000/1", bus.out_data, bus.out_valid);
    end else $display("ok   add_wrap");
    for (int i = 0; i < 2; i++) begin
      drive(32'd5, 32'd5, ALU_ADD, 1'b0, 1'b0);
      checks++;
      if (bus.out_data !== 32'd0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: data=%h valid=%b expected 00000000/0", i, bus.out_data, bus.out_valid);
      end else $display("ok   idle_hold[%0d]", i);
    end
  endtask

`ifdef RV_ALU_ALT_OPS_EN
  task automatic test_alt();
    logic [31:0] va[] = '{32'd3, 32'h8000_0000, 32'd3, 32'h8000_0000, 32'd3};
    logic [31:0] vb[] = '{32'd5, 32'd4,          32'd5, 32'd4,         32'd4};
    logic [2:0]  vs[] = '{ALU_ADD, ALU_SRL, ALU_ADD, ALU_SRL, ALU_OR};
    logic        vl[] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ve[] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd8, 32'h0800_0000, 32'd7};
    for (int i = 0; i < va.size(); i++) begin
      drive(va[i], vb[i], vs[i], vl[i], 1'b1);
      checks++;
      if (bus.out_data !== ve[i] || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL alt[%0d]: data=%h valid=%b expected %h/1", i, bus.out_data, bus.out_valid, ve[i]);
      end else $display("ok   alt[%0d] data=%h", i, bus.out_data);
    end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.in_select = ALU_ADD;
`ifdef RV_ALU_ALT_OPS_EN
    bus.in_alt    = 1'b0;
`endif
    #1;
    checks++;
    if (bus.out_data !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset: data=%h valid=%b expected 00000000/0", bus.out_data, bus.out_valid);
    end else $display("ok   power_on_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_logic();
    test_shifts();
    test_compares();
    test_wrap_hold();
`ifdef RV_ALU_ALT_OPS_EN
    test_alt();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
